lmg_result_writer: RTL and testbench

Drains the legal-move-generator output FIFO and writes each 152-bit move entry into the control block's slave-visible result RAM as five consecutive 32-bit words, starting at word address 16. It sits between the LMG move FIFO and the write port of the control RAM. It reports the number of moves written (writeCount) and a done flag that the Avalon status word exposes to software.

---
 rtl/lmg_pkg.sv | 29 ++
 rtl/lmg_result_writer_if.sv | 39 +++
 rtl/lmg_result_writer_entry_word_sel.sv | 34 +++
 rtl/lmg_result_writer.sv | 169 ++++++++++++++++
 tb/tb_lmg_result_writer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lmg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lmg_pkg
//  Description : Shared constants and FSM state encoding for the LMG result
//                writer (move FIFO -> control RAM drain path).
//  Revision    : 1.0 - initial release
// ============================================================================
package lmg_pkg;

    // RAM word address of move 0, word 0
    localparam int BASE_ADDR      = 16;
    // 32-bit RAM words used to store one 152-bit move entry
    localparam int WORDS_PER_MOVE = 5;
    // Width of one LMG FIFO entry
    localparam int ENTRY_WIDTH    = 152;
    // Entries beyond this count are discarded and flagged as overflow
    localparam int MAX_MOVES      = 218;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        POP   = 3'd2,
        LATCH = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lmg_result_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lmg_result_writer_if
//  Description : FIFO read side and RAM write port bundle between the LMG
//                move FIFO, the result writer and the control-block RAM.
//                master = result writer, slave = FIFO/RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lmg_result_writer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 15,
    parameter int ENTRY_WIDTH = lmg_pkg::ENTRY_WIDTH
);
    logic                   fifoEmpty;
    logic [ENTRY_WIDTH-1:0] fifoData;
    logic                   fifoRdreq;
    logic                   ram_wren;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0]  ram_wdata;

    modport master (
        input  fifoEmpty,
        input  fifoData,
        output fifoRdreq,
        output ram_wren,
        output ram_addr,
        output ram_wdata
    );

    modport slave (
        output fifoEmpty,
        output fifoData,
        input  fifoRdreq,
        input  ram_wren,
        input  ram_addr,
        input  ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lmg_result_writer_entry_word_sel.sv
`default_nettype none
// ============================================================================
//  Module      : entry_word_sel
//  Description : Picks RAM word k of a move entry. The entry is zero-extended
//                to a whole number of words, so the last word carries the
//                top entry bits with zero padding above them.
//  Revision    : 1.0 - initial release
// ============================================================================
module entry_word_sel #(
    parameter int DATA_WIDTH  = 32,
    parameter int ENTRY_WIDTH = 152,
    parameter int WORDS       = 5
) (
    input  wire logic [ENTRY_WIDTH-1:0] entry_i,
    input  wire logic [2:0]             k_i,
    output logic      [DATA_WIDTH-1:0]  word_o
);
    localparam int PAD_W = WORDS * DATA_WIDTH - ENTRY_WIDTH;

    logic [WORDS*DATA_WIDTH-1:0] padded;

    assign padded = {{PAD_W{1'b0}}, entry_i};

    // Word multiplexer; an out-of-range index returns zero
    always_comb begin
        word_o = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k_i == 3'(i)) begin
                word_o = padded[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/lmg_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : lmg_result_writer
//  Description : Drains the LMG move FIFO and stores each 152-bit entry as
//                five consecutive 32-bit words in the control RAM, starting
//                at BASE_ADDR. Reports moves written, done and overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module lmg_result_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 15,
    parameter int ENTRY_WIDTH = lmg_pkg::ENTRY_WIDTH,
    parameter int BASE_ADDR   = lmg_pkg::BASE_ADDR,
    parameter int MAX_MOVES   = lmg_pkg::MAX_MOVES
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                start,
    input  wire logic                lmgDone,
    lmg_result_writer_if.master      bus,
    output logic [7:0]               writeCount,
    output logic                     done,
    output logic                     overflow
);
    import lmg_pkg::*;

    localparam logic [2:0] LAST_K = 3'(WORDS_PER_MOVE - 1);

    state_t                  state_q, state_d;
    logic [2:0]              k_q, k_d;
    logic [7:0]              count_q, count_d;
    logic [ENTRY_WIDTH-1:0]  entry_q, entry_d;
    logic                    latch_q, latch_d;
    logic                    rdreq_q, rdreq_d;
    logic                    wren_q, wren_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    logic [ADDR_WIDTH-1:0]   count_ext;
    logic [ADDR_WIDTH-1:0]   move_base;
    logic [DATA_WIDTH-1:0]   sel_word;

    // Start address of the current move: BASE + 5*count, 5x done as shift+add
    assign count_ext = ADDR_WIDTH'(count_q);
    assign move_base = ADDR_WIDTH'(BASE_ADDR) + (count_ext << 2) + count_ext;

    // Word select looks at next-cycle entry/index so the RAM outputs register
    // the data belonging to the write they accompany.
    entry_word_sel #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ENTRY_WIDTH (ENTRY_WIDTH),
        .WORDS       (WORDS_PER_MOVE)
    ) u_word_sel (
        .entry_i (entry_d),
        .k_i     (k_d),
        .word_o  (sel_word)
    );

    // Next-state logic and next values of all registered outputs
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        count_d = count_q;
        entry_d = entry_q;
        latch_d = latch_q | (lmgDone && (state_q != IDLE));
        ovf_d   = ovf_q;

        if (start) begin
            state_d = WAIT;
            k_d     = 3'd0;
            count_d = 8'd0;
            latch_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                WAIT: begin
                    // Remaining entries are drained before done is honoured
                    if (!bus.fifoEmpty) begin
                        state_d = POP;
                    end else if (latch_q || lmgDone) begin
                        state_d = DONE;
                    end
                end
                POP: begin
                    state_d = LATCH;
                end
                LATCH: begin
                    entry_d = bus.fifoData;
                    if (count_q == 8'(MAX_MOVES)) begin
                        ovf_d   = 1'b1;
                        state_d = WAIT;
                    end else begin
                        k_d     = 3'd0;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (k_q == LAST_K) begin
                        k_d     = 3'd0;
                        count_d = count_q + 8'd1;
                        state_d = WAIT;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        rdreq_d = (state_d == POP);
        wren_d  = (state_d == WRITE);
        done_d  = (state_d == DONE);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (wren_d) begin
            addr_d  = move_base + ADDR_WIDTH'(k_d);
            wdata_d = sel_word;
        end
    end

    // State and output registers, synchronous reset has priority over start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            count_q <= 8'd0;
            entry_q <= '0;
            latch_q <= 1'b0;
            rdreq_q <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            count_q <= count_d;
            entry_q <= entry_d;
            latch_q <= latch_d;
            rdreq_q <= rdreq_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.fifoRdreq = rdreq_q;
    assign bus.ram_wren  = wren_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign writeCount    = count_q;
    assign done          = done_q;
    assign overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lmg_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lmg_result_writer
//  Description : Directed bench for lmg_result_writer with a behavioural
//                normal-mode FIFO and a RAM capture model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lmg_result_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       lmgDone;
    logic [7:0] writeCount;
    logic       done;
    logic       overflow;

    lmg_result_writer_if bus ();

    always #5 clk = ~clk;

    lmg_result_writer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .lmgDone    (lmgDone),
        .bus        (bus),
        .writeCount (writeCount),
        .done       (done),
        .overflow   (overflow)
    );

    // Normal-mode FIFO: data appears the cycle after the read request
    logic [151:0] fmem [0:511];
    int wr_ptr   = 0;
    int rd_ptr   = 0;
    int pops     = 0;
    int bad_pops = 0;

    assign bus.fifoEmpty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifoRdreq) begin
            if (wr_ptr == rd_ptr) begin
                bad_pops <= bad_pops + 1;
            end else begin
                bus.fifoData <= fmem[rd_ptr[8:0]];
                rd_ptr       <= rd_ptr + 1;
            end
            pops <= pops + 1;
        end
    end

    // RAM capture
    logic [31:0] ram [0:2047];
    int          n_wr = 0;
    logic [14:0] last_addr = '0;

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            ram[bus.ram_addr[10:0]] <= bus.ram_wdata;
            n_wr                    <= n_wr + 1;
            last_addr               <= bus.ram_addr;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [151:0] e);
        fmem[wr_ptr[8:0]] = e;
        wr_ptr++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int i = 0;
        while (!done && i < bound) begin
            step();
            i++;
        end
        chk({tag, "_done_reached"}, 32'(done), 32'd1);
    endtask

    // Entry n: words (k0..k4) = D000_0000+n, C..+n, B..+n, A..+n, 00 & n[23:0]
    function automatic logic [151:0] mk(input int n);
        logic [23:0] top;
        top = 24'(n);
        return {top, 32'hA000_0000 + 32'(n), 32'hB000_0000 + 32'(n),
                32'hC000_0000 + 32'(n), 32'hD000_0000 + 32'(n)};
    endfunction

    initial begin
        int i;
        int snap_wr;
        int snap_pop;
        logic found;

        reset   = 1'b1;
        start   = 1'b0;
        lmgDone = 1'b0;
        repeat (3) step();

        // ---- reset state
        chk("rst_rdreq", 32'(bus.fifoRdreq), 32'd0);
        chk("rst_wren",  32'(bus.ram_wren),  32'd0);
        chk("rst_addr",  32'(bus.ram_addr),  32'd0);
        chk("rst_wdata", bus.ram_wdata,      32'd0);
        chk("rst_count", 32'(writeCount),    32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_ovf",   32'(overflow),      32'd0);
        reset = 1'b0;
        step();

        // ---- reset in the middle of a move (word 2 on the bus)
        pulse_start();
        push(mk(8'h5A));
        i = 0;
        found = 1'b0;
        while (!found && i < 50) begin
            if (bus.ram_wren && bus.ram_addr == 15'd18) found = 1'b1;
            else begin
                step();
                i++;
            end
        end
        chk("midwr_reached_k2", 32'(found), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midwr_wren",  32'(bus.ram_wren), 32'd0);
        chk("midwr_addr",  32'(bus.ram_addr), 32'd0);
        chk("midwr_wdata", bus.ram_wdata,     32'd0);
        chk("midwr_count", 32'(writeCount),   32'd0);
        snap_wr = n_wr;
        lmgDone = 1'b1;
        step();
        lmgDone = 1'b0;
        repeat (20) step();
        chk("midwr_idle_nowrites", 32'(n_wr - snap_wr), 32'd0);
        chk("midwr_idle_nodone",   32'(done),           32'd0);

        // ---- single entry
        pulse_start();
        push(152'h00A1B2C3_11111111_22222222_33333333_44444444);
        lmgDone = 1'b1;
        step();
        lmgDone = 1'b0;
        i = 0;
        found = 1'b0;
        while (!found && i < 40) begin
            if (bus.ram_wren && bus.ram_addr == 15'd20) found = 1'b1;
            else begin
                step();
                i++;
            end
        end
        chk("one_last_write_seen", 32'(found), 32'd1);
        step();
        chk("one_done_plus1", 32'(done),       32'd0);
        chk("one_count",      32'(writeCount), 32'd1);
        step();
        chk("one_done_plus2", 32'(done), 32'd1);
        chk("one_ram16", ram[16], 32'h44444444);
        chk("one_ram17", ram[17], 32'h33333333);
        chk("one_ram18", ram[18], 32'h22222222);
        chk("one_ram19", ram[19], 32'h11111111);
        chk("one_ram20", ram[20], 32'h00A1B2C3);

        // ---- three entries, lmgDone already high while FIFO non-empty
        pulse_start();
        snap_wr  = n_wr;
        snap_pop = pops;
        push(mk(8'h10));
        push(mk(8'h11));
        push(mk(8'h12));
        lmgDone = 1'b1;
        wait_done(200, "three");
        lmgDone = 1'b0;
        chk("three_fifo_empty", 32'(bus.fifoEmpty),    32'd1);
        chk("three_pops",       32'(pops - snap_pop),  32'd3);
        chk("three_writes",     32'(n_wr - snap_wr),   32'd15);
        chk("three_last_addr",  32'(last_addr),        32'd30);
        chk("three_count",      32'(writeCount),       32'd3);
        chk("three_ram16",      ram[16], 32'hD0000010);
        chk("three_ram20",      ram[20], 32'h00000010);
        chk("three_ram21",      ram[21], 32'hD0000011);
        chk("three_ram28",      ram[28], 32'hB0000012);
        chk("three_ram30",      ram[30], 32'h00000012);

        // ---- done with an empty FIFO
        pulse_start();
        snap_wr = n_wr;
        lmgDone = 1'b1;
        step();
        lmgDone = 1'b0;
        wait_done(10, "empty");
        chk("empty_writes", 32'(n_wr - snap_wr), 32'd0);
        chk("empty_count",  32'(writeCount),     32'd0);

        // ---- 220 entries: last two discarded
        pulse_start();
        snap_wr  = n_wr;
        snap_pop = pops;
        for (int n = 0; n < 220; n++) push(mk(n));
        lmgDone = 1'b1;
        step();
        lmgDone = 1'b0;
        wait_done(3000, "full");
        chk("full_count",     32'(writeCount),      32'd218);
        chk("full_ovf",       32'(overflow),        32'd1);
        chk("full_pops",      32'(pops - snap_pop), 32'd220);
        chk("full_writes",    32'(n_wr - snap_wr),  32'd1090);
        chk("full_last_addr", 32'(last_addr),       32'd1105);
        chk("full_ram16",     ram[16],   32'hD0000000);
        chk("full_ram1101",   ram[1101], 32'hD00000D9);
        chk("full_ram1105",   ram[1105], 32'h000000D9);

        // ---- restart from DONE with five moves stored
        pulse_start();
        chk("five_ovf_cleared", 32'(overflow), 32'd0);
        for (int n = 32; n < 37; n++) push(mk(n));
        lmgDone = 1'b1;
        step();
        lmgDone = 1'b0;
        wait_done(100, "five");
        chk("five_count", 32'(writeCount), 32'd5);
        pulse_start();
        chk("restart_done",  32'(done),       32'd0);
        chk("restart_count", 32'(writeCount), 32'd0);
        chk("restart_ovf",   32'(overflow),   32'd0);
        push(mk(8'h77));
        lmgDone = 1'b1;
        step();
        lmgDone = 1'b0;
        wait_done(50, "restart");
        chk("restart_ram16",   ram[16], 32'hD0000077);
        chk("restart_ram20",   ram[20], 32'h00000077);
        chk("restart_count1",  32'(writeCount), 32'd1);

        chk("no_pop_when_empty", 32'(bad_pops), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
